// File: rtl/ncl_pkg.sv
// rtl/ncl_pkg.sv - dual-rail (NCL) rail codes, codec helpers and bridge FSM states
//
// Purpose: shared definitions for the NCL adder bridge.
//   - Rail codes for one dual-rail digit.
//   - Binary <-> dual-rail conversion functions.
//   - Completion and illegal-code detection functions.
//   - The bridge FSM state type.
//   Helpers work on a fixed maximum width (NCL_MAXB digits). Callers zero-extend
//   their buses into that width, and pass the number of live digits where it matters.
// Ports: none (package).
package ncl_pkg;

   localparam logic [1:0] NCL_NULL = 2'b00;
   localparam logic [1:0] NCL_D0   = 2'b01;
   localparam logic [1:0] NCL_D1   = 2'b10;
   localparam logic [1:0] NCL_ILL  = 2'b11;

   localparam int NCL_MAXB = 16;
   localparam int NCL_DRW  = 2 * NCL_MAXB;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_NULL = 2'd2,
      ST_FAIL = 2'd3
   } ncl_state_t;

   function automatic logic [NCL_DRW-1:0] dr_encode(input logic [NCL_MAXB-1:0] bin);
      logic [NCL_DRW-1:0] dr;
      dr = '0;
      for (int i = 0; i < NCL_MAXB; i++) begin
         dr[2*i +: 2] = bin[i] ? NCL_D1 : NCL_D0;
      end
      return dr;
   endfunction

   function automatic logic [NCL_MAXB-1:0] dr_decode(input logic [NCL_DRW-1:0] dr);
      logic [NCL_MAXB-1:0] bin;
      bin = '0;
      for (int i = 0; i < NCL_MAXB; i++) begin
         bin[i] = (dr[2*i +: 2] == NCL_D1);
      end
      return bin;
   endfunction

   function automatic logic is_complete_data(input logic [NCL_DRW-1:0] dr, input int n);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < NCL_MAXB; i++) begin
         if (i < n && (dr[2*i +: 2] == NCL_NULL || dr[2*i +: 2] == NCL_ILL)) ok = 1'b0;
      end
      return ok;
   endfunction

   function automatic logic is_complete_null(input logic [NCL_DRW-1:0] dr, input int n);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < NCL_MAXB; i++) begin
         if (i < n && dr[2*i +: 2] != NCL_NULL) ok = 1'b0;
      end
      return ok;
   endfunction

   function automatic logic has_illegal(input logic [NCL_DRW-1:0] dr, input int n);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < NCL_MAXB; i++) begin
         if (i < n && dr[2*i +: 2] == NCL_ILL) bad = 1'b1;
      end
      return bad;
   endfunction

endpackage

// File: rtl/ncl_sync2.sv
// rtl/ncl_sync2.sv - two-flop synchronizer for asynchronous dual-rail inputs
//
// Purpose: brings the asynchronous adder outputs into the clk domain.
// Ports:
//   clk    in  1  rising-edge clock
//   rst_n  in  1  synchronous active-low reset, clears both stages to 0
//   d      in  W  asynchronous input bus
//   q      out W  synchronized bus (second stage)
module ncl_sync2 #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ncl_adder_sync_bridge.sv
// rtl/ncl_adder_sync_bridge.sv - clocked four-phase front/back end for a dual-rail NCL adder
//
// Purpose: accepts binary operands over valid/ready, drives them as one DATA
//   wavefront, captures sum/overflow once the synchronized result is complete and
//   stable, then drives NULL and waits for the adder to return to NULL.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       operand handshake; in_a, in_b (two's complement), in_cin
//   out_valid/out_ready     result handshake; out_sum, out_ovf, out_err
//   dr_a, dr_b, dr_cin      dual-rail operands to the adder
//   dr_s, dr_ovf            dual-rail result from the adder (asynchronous)
//   busy                    high whenever the FSM is not idle
module ncl_adder_sync_bridge #(
   parameter int NBITS   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [NBITS-1:0]   in_a,
   input  logic [NBITS-1:0]   in_b,
   input  logic               in_cin,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NBITS-1:0]   out_sum,
   output logic               out_ovf,
   output logic               out_err,
   output logic [2*NBITS-1:0] dr_a,
   output logic [2*NBITS-1:0] dr_b,
   output logic [1:0]         dr_cin,
   input  logic [2*NBITS-1:0] dr_s,
   input  logic [1:0]         dr_ovf,
   output logic               busy
);
   import ncl_pkg::*;

   // Result bundle: overflow is treated as one extra digit above the sum digits.
   localparam int SW = 2*NBITS + 2;
   localparam int ND = NBITS + 1;

   ncl_state_t       state, state_nxt;
   logic [SW-1:0]    sync_q;
   logic [SW-1:0]    prev_q;
   logic [NBITS-1:0] a_q, b_q;
   logic             cin_q;
   logic [7:0]       wait_cnt;
   logic [NBITS:0]   dec;
   logic             cmp_d, cmp_n, ill, stable, tmo, accept;
   logic             capture_ok, capture_err;

   ncl_sync2 #(.W(SW)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({dr_ovf, dr_s}),
      .q     (sync_q)
   );

   always_comb begin
      // stable means the synchronized code held its value across the last edge;
      // combined with completion this fires on the second consecutive edge that
      // sees the same complete code.
      stable   = (sync_q == prev_q);
      cmp_d    = is_complete_data(NCL_DRW'(sync_q), ND);
      cmp_n    = is_complete_null(NCL_DRW'(sync_q), ND);
      ill      = has_illegal(NCL_DRW'(sync_q), ND);
      dec      = (NBITS+1)'(dr_decode(NCL_DRW'(sync_q)));
      // Counter starts at 0 on state entry, so TIMEOUT-1 marks the last allowed cycle.
      tmo      = (wait_cnt == 8'(TIMEOUT - 1));
      in_ready = rst_n && (state == ST_IDLE) && !out_valid;
      accept   = in_valid && in_ready;
      busy     = (state != ST_IDLE);
   end

   always_comb begin
      dr_a   = '0;
      dr_b   = '0;
      dr_cin = NCL_NULL;
      if (state == ST_DATA) begin
         dr_a   = (2*NBITS)'(dr_encode(NCL_MAXB'(a_q)));
         dr_b   = (2*NBITS)'(dr_encode(NCL_MAXB'(b_q)));
         dr_cin = cin_q ? NCL_D1 : NCL_D0;
      end
   end

   always_comb begin
      state_nxt   = state;
      capture_ok  = 1'b0;
      capture_err = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (ill) begin
               capture_err = 1'b1;
               state_nxt   = ST_NULL;
            end else if (cmp_d && stable) begin
               capture_ok  = 1'b1;
               state_nxt   = ST_NULL;
            end else if (tmo) begin
               capture_err = 1'b1;
               state_nxt   = ST_NULL;
            end
         end
         ST_NULL: begin
            if (cmp_n && stable) state_nxt = ST_IDLE;
            else if (tmo)        state_nxt = ST_FAIL;
         end
         ST_FAIL: state_nxt = ST_FAIL;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         prev_q    <= '0;
         a_q       <= '0;
         b_q       <= '0;
         cin_q     <= 1'b0;
         wait_cnt  <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_ovf   <= 1'b0;
         out_err   <= 1'b0;
      end else begin
         state  <= state_nxt;
         prev_q <= sync_q;

         if (state_nxt != state)
            wait_cnt <= '0;
         else if (state == ST_DATA || state == ST_NULL)
            wait_cnt <= wait_cnt + 8'd1;

         if (accept) begin
            a_q   <= in_a;
            b_q   <= in_b;
            cin_q <= in_cin;
         end

         if (capture_ok) begin
            out_valid <= 1'b1;
            out_sum   <= dec[NBITS-1:0];
            out_ovf   <= dec[NBITS];
            out_err   <= 1'b0;
         end else if (capture_err) begin
            out_valid <= 1'b1;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_err   <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ncl_adder_sync_bridge.sv
// tb/tb_ncl_adder_sync_bridge.sv - directed-vector bench for the NCL adder bridge
//
// Purpose: drives a main bridge (TIMEOUT=255) against a behavioural dual-rail
//   adder (zero-delay or slow with a partial wavefront) and a second bridge
//   (TIMEOUT=8) against hand-set stuck/illegal rail codes.
// Ports: none.
module tb_ncl_adder_sync_bridge;

   logic       clk, rst_n;
   logic       in_valid, t_valid, out_ready;
   logic [3:0] in_a, in_b;
   logic       in_cin;

   logic       in_ready, out_valid, out_ovf, out_err, busy;
   logic [3:0] out_sum;
   logic [7:0] dr_a, dr_b, m_s;
   logic [1:0] dr_cin, m_ovf;

   logic       t_ready, t_out_valid, t_ovf, t_err, t_busy;
   logic [3:0] t_sum;
   logic [7:0] t_dr_a, t_dr_b, t_s;
   logic [1:0] t_dr_cin, t_ovf_in;

   logic       slow;
   logic [7:0] dcnt;

   int n_vec = 0;
   int n_bad = 0;

   ncl_adder_sync_bridge #(.NBITS(4), .TIMEOUT(255)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf), .out_err(out_err),
      .dr_a(dr_a), .dr_b(dr_b), .dr_cin(dr_cin), .dr_s(m_s), .dr_ovf(m_ovf), .busy(busy)
   );

   ncl_adder_sync_bridge #(.NBITS(4), .TIMEOUT(8)) dut_to (
      .clk(clk), .rst_n(rst_n), .in_valid(t_valid), .in_ready(t_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(t_out_valid),
      .out_ready(out_ready), .out_sum(t_sum), .out_ovf(t_ovf), .out_err(t_err),
      .dr_a(t_dr_a), .dr_b(t_dr_b), .dr_cin(t_dr_cin), .dr_s(t_s), .dr_ovf(t_ovf_in), .busy(t_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] tb_enc(input logic [3:0] v);
      logic [7:0] r;
      for (int i = 0; i < 4; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
      return r;
   endfunction

   function automatic logic [3:0] tb_dec(input logic [7:0] d);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (d[2*i +: 2] == 2'b10);
      return r;
   endfunction

   // Behavioural adder: zero-delay, or slow (partial low digits at 5 cycles, full at 10).
   always @(posedge clk) dcnt <= (dr_a != 8'd0) ? ((dcnt == 8'hFF) ? dcnt : dcnt + 8'd1) : 8'd0;

   always_comb begin
      logic [3:0] ma, mb, s4;
      logic [4:0] s5;
      logic       ov;
      logic [7:0] full_s;
      ma     = tb_dec(dr_a);
      mb     = tb_dec(dr_b);
      s5     = {1'b0, ma} + {1'b0, mb} + {4'd0, (dr_cin == 2'b10)};
      s4     = s5[3:0];
      ov     = (ma[3] == mb[3]) && (s4[3] != ma[3]);
      full_s = tb_enc(s4);
      m_s    = 8'd0;
      m_ovf  = 2'b00;
      if (dr_a != 8'd0) begin
         if (!slow || dcnt >= 8'd10) begin
            m_s   = full_s;
            m_ovf = ov ? 2'b10 : 2'b01;
         end else if (dcnt >= 8'd5) begin
            m_s = {4'b0000, full_s[3:0]};
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic accept(input logic [3:0] a, input logic [3:0] b, input logic c);
      chk("acc_in_ready", in_ready, 1);
      in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic c, input logic [3:0] es, input logic eo);
      accept(a, b, c);
      for (int i = 0; i < 40 && !out_valid; i++) tick();
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_sum"}, out_sum, es);
      chk({tag, "_ovf"}, out_ovf, eo);
      chk({tag, "_err"}, out_err, 0);
      consume();
      for (int i = 0; i < 40 && busy; i++) tick();
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      logic early;
      rst_n = 1'b0; in_valid = 1'b0; t_valid = 1'b0; out_ready = 1'b0;
      in_a = 4'h0; in_b = 4'h0; in_cin = 1'b0; slow = 1'b0;
      t_s = 8'd0; t_ovf_in = 2'b00;

      // Reset state
      repeat (2) tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dr", {dr_a, dr_b, dr_cin}, 0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", in_ready, 1);

      // 3 + 4: exact latency
      accept(4'h3, 4'h4, 1'b0);
      chk("v1_dr_a", dr_a, 8'b01011010);
      chk("v1_dr_b", dr_b, 8'b01100101);
      chk("v1_dr_cin", dr_cin, 2'b01);
      chk("v1_busy", busy, 1);
      repeat (3) tick();
      chk("v1_valid_k3", out_valid, 0);
      tick();
      chk("v1_valid_k4", out_valid, 1);
      chk("v1_sum", out_sum, 4'h7);
      chk("v1_ovf", out_ovf, 0);
      chk("v1_err", out_err, 0);
      repeat (3) tick();
      chk("v1_busy_k7", busy, 1);
      tick();
      chk("v1_busy_k8", busy, 0);
      chk("v1_in_ready_held", in_ready, 0);
      consume();
      chk("v1_valid_clr", out_valid, 0);
      chk("v1_in_ready_back", in_ready, 1);

      run_op("v2", 4'h7, 4'h1, 1'b0, 4'h8, 1'b1);
      run_op("v3", 4'hF, 4'hF, 1'b1, 4'hF, 1'b0);
      run_op("v4", 4'h8, 4'h8, 1'b0, 4'h0, 1'b1);

      // Slow adder with partial wavefront: 5 + 6 + 1 = 12 (signed overflow)
      slow = 1'b1;
      accept(4'h5, 4'h6, 1'b1);
      early = 1'b0;
      for (int i = 0; i < 13; i++) begin
         tick();
         if (out_valid) early = 1'b1;
      end
      chk("slow_no_early", early, 0);
      tick();
      chk("slow_valid_k14", out_valid, 1);
      chk("slow_sum", out_sum, 4'hC);
      chk("slow_ovf", out_ovf, 1);
      consume();
      for (int i = 0; i < 40 && busy; i++) tick();
      chk("slow_idle", busy, 0);
      slow = 1'b0;

      // Back-pressure: result held, no accept while out_valid
      accept(4'h2, 4'h3, 1'b0);
      for (int i = 0; i < 40 && !out_valid; i++) tick();
      chk("bp_valid", out_valid, 1);
      in_valid = 1'b1; in_a = 4'h1; in_b = 4'h1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("bp_sum", out_sum, 4'h5);
         chk("bp_in_ready", in_ready, 0);
      end
      chk("bp_no_accept", busy, 0);
      in_valid = 1'b0;
      consume();
      chk("bp_valid_clr", out_valid, 0);
      chk("bp_in_ready_back", in_ready, 1);

      // Timeout bridge: partial code never completes DATA nor returns to NULL
      t_s = 8'b00000101;
      repeat (3) tick();
      chk("to_in_ready", t_ready, 1);
      t_valid = 1'b1;
      tick();
      t_valid = 1'b0;
      repeat (7) tick();
      chk("to_valid_k7", t_out_valid, 0);
      tick();
      chk("to_valid_k8", t_out_valid, 1);
      chk("to_err", t_err, 1);
      chk("to_sum", t_sum, 0);
      chk("to_ovf", t_ovf, 0);
      repeat (12) tick();
      consume();
      t_valid = 1'b1;
      repeat (3) tick();
      t_valid = 1'b0;
      chk("fail_valid_clr", t_out_valid, 0);
      chk("fail_in_ready", t_ready, 0);
      chk("fail_busy", t_busy, 1);
      chk("fail_dr_null", {t_dr_a, t_dr_b, t_dr_cin}, 0);
      rst_n = 1'b0;
      tick();
      chk("fail_rst_busy", t_busy, 0);
      rst_n = 1'b1;
      tick();
      chk("fail_rst_in_ready", t_ready, 1);

      // Illegal rail code on the timeout bridge
      t_s = 8'b00000011;
      repeat (3) tick();
      t_valid = 1'b1;
      tick();
      t_valid = 1'b0;
      tick();
      chk("ill_valid", t_out_valid, 1);
      chk("ill_err", t_err, 1);
      t_s = 8'd0;
      consume();
      for (int i = 0; i < 40 && t_busy; i++) tick();
      chk("ill_idle", t_busy, 0);

      // Reset during DATA on the main bridge
      slow = 1'b1;
      accept(4'h1, 4'h1, 1'b0);
      repeat (3) tick();
      chk("rd_busy", busy, 1);
      rst_n = 1'b0;
      tick();
      chk("rd_dr_null", {dr_a, dr_b, dr_cin}, 0);
      chk("rd_out_valid", out_valid, 0);
      chk("rd_idle", busy, 0);
      rst_n = 1'b1;
      slow = 1'b0;
      tick();
      run_op("v5", 4'h1, 4'h2, 1'b1, 4'h4, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
